control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 115 +++++++++++
 rtl/control_decode.sv | 38 +++
 rtl/control_unit.sv | 137 +++++++++++++
 tb/tb_control_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Opcodes, instruction classes, FSM states and per-state controls.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam logic [4:0] C_OP_LD   = 5'b00000;
  localparam logic [4:0] C_OP_LDI  = 5'b00001;
  localparam logic [4:0] C_OP_ST   = 5'b00010;
  localparam logic [4:0] C_OP_ADD  = 5'b00011;
  localparam logic [4:0] C_OP_SUB  = 5'b00100;
  localparam logic [4:0] C_OP_AND  = 5'b00101;
  localparam logic [4:0] C_OP_OR   = 5'b00110;
  localparam logic [4:0] C_OP_ROR  = 5'b00111;
  localparam logic [4:0] C_OP_ROL  = 5'b01000;
  localparam logic [4:0] C_OP_SHR  = 5'b01001;
  localparam logic [4:0] C_OP_SHRA = 5'b01010;
  localparam logic [4:0] C_OP_SHL  = 5'b01011;
  localparam logic [4:0] C_OP_ADDI = 5'b01100;
  localparam logic [4:0] C_OP_ANDI = 5'b01101;
  localparam logic [4:0] C_OP_ORI  = 5'b01110;
  localparam logic [4:0] C_OP_DIV  = 5'b01111;
  localparam logic [4:0] C_OP_MUL  = 5'b10000;
  localparam logic [4:0] C_OP_NEG  = 5'b10001;
  localparam logic [4:0] C_OP_NOT  = 5'b10010;
  localparam logic [4:0] C_OP_BR   = 5'b10011;
  localparam logic [4:0] C_OP_JR   = 5'b10100;
  localparam logic [4:0] C_OP_JAL  = 5'b10101;
  localparam logic [4:0] C_OP_IN   = 5'b10110;
  localparam logic [4:0] C_OP_OUT  = 5'b10111;
  localparam logic [4:0] C_OP_MFHI = 5'b11000;
  localparam logic [4:0] C_OP_MFLO = 5'b11001;
  localparam logic [4:0] C_OP_NOP  = 5'b11010;
  localparam logic [4:0] C_OP_HALT = 5'b11011;
  localparam logic [4:0] C_ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_UNARY, CLS_MULDIV, CLS_IMM, CLS_LD, CLS_LDI, CLS_ST,
    CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT
  } instr_class_t;

  typedef enum logic [5:0] {
    S_RESET, S_HALT, S_T0, S_T1, S_T2,
    S_ALU_T3, S_ALU_T4, S_ALU_T5,
    S_UN_T3, S_UN_T4, S_UN_T5,
    S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6,
    S_IMM_T3, S_IMM_T4, S_IMM_T5,
    S_MEM_T3, S_MEM_T4,
    S_LD_T5, S_LD_T6, S_LD_T7,
    S_LDI_T5,
    S_ST_T5, S_ST_T6, S_ST_T7,
    S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
    S_JR_T3, S_JAL_T3, S_JAL_T4,
    S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3
  } state_t;

  typedef struct packed {
    logic [4:0] op;
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out;
    logic c_out, ba_out, r_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, zhigh_in, zlow_in, hi_in, lo_in;
    logic outport_in, con_in, r_in;
    logic gra, grb, grc, inc_pc, read, write;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [4:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_T0:       begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1;
                        c.zhigh_in = 1'b1; c.zlow_in = 1'b1; end
      S_T1:       begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      S_T2:       begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_ALU_T3, S_UN_T3, S_IMM_T3:
                  begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
      S_ALU_T4:   begin c.grc = 1'b1; c.r_out = 1'b1; c.op = opc;
                        c.zhigh_in = 1'b1; c.zlow_in = 1'b1; end
      S_UN_T4, S_MD_T4:
                  begin c.grb = 1'b1; c.r_out = 1'b1; c.op = opc;
                        c.zhigh_in = 1'b1; c.zlow_in = 1'b1; end
      S_ALU_T5, S_UN_T5, S_IMM_T5, S_LDI_T5:
                  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_MD_T3:    begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
      S_MD_T5:    begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
      S_MD_T6:    begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
      S_IMM_T4:   begin c.c_out = 1'b1; c.op = opc; c.zhigh_in = 1'b1; c.zlow_in = 1'b1; end
      S_MEM_T3:   begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
      S_MEM_T4, S_BR_T5:
                  begin c.c_out = 1'b1; c.op = C_ALU_ADD; c.zhigh_in = 1'b1; c.zlow_in = 1'b1; end
      S_LD_T5, S_ST_T5:
                  begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
      S_LD_T6:    begin c.read = 1'b1; c.mdr_in = 1'b1; end
      S_LD_T7:    begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_ST_T6:    begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
      S_ST_T7:    c.write = 1'b1;
      S_BR_T3:    begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
      S_BR_T4:    begin c.pc_out = 1'b1; c.y_in = 1'b1; end
      S_BR_T6:    c.zlow_out = 1'b1;
      S_JR_T3, S_JAL_T4:
                  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
      S_JAL_T3:   begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
      S_IN_T3:    begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_OUT_T3:   begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
      S_MFHI_T3:  begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_MFLO_T3:  begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Brief    : Combinational opcode-to-instruction-class decoder.
// Revision : 1.0
// ============================================================================
module control_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t instr_class
);

  always_comb begin
    instr_class = CLS_NOP;
    case (opcode)
      C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_ROR,
      C_OP_ROL, C_OP_SHR, C_OP_SHRA, C_OP_SHL: instr_class = CLS_ALU;
      C_OP_NEG, C_OP_NOT:                      instr_class = CLS_UNARY;
      C_OP_MUL, C_OP_DIV:                      instr_class = CLS_MULDIV;
      C_OP_ADDI, C_OP_ANDI, C_OP_ORI:          instr_class = CLS_IMM;
      C_OP_LD:                                 instr_class = CLS_LD;
      C_OP_LDI:                                instr_class = CLS_LDI;
      C_OP_ST:                                 instr_class = CLS_ST;
      C_OP_BR:                                 instr_class = CLS_BR;
      C_OP_JR:                                 instr_class = CLS_JR;
      C_OP_JAL:                                instr_class = CLS_JAL;
      C_OP_IN:                                 instr_class = CLS_IN;
      C_OP_OUT:                                instr_class = CLS_OUT;
      C_OP_MFHI:                               instr_class = CLS_MFHI;
      C_OP_MFLO:                               instr_class = CLS_MFLO;
      C_OP_HALT:                               instr_class = CLS_HALT;
      default:                                 instr_class = CLS_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Moore control FSM sequencing fetch and execute steps of the CPU.
// Revision : 1.0
// ============================================================================
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        branchCompare,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  op,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
  output logic        InPortout, Cout, BAout, Rout,
  output logic        PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin,
  output logic        HIin, LOin, OutPortin, CONin, Rin,
  output logic        Gra, Grb, Grc, IncPC, Read, Write
);

  state_t       r_state;
  state_t       w_next;
  ctrl_t        r_ctrl;
  logic         r_run;
  instr_class_t w_class;
  logic         w_unused_ir;

  assign w_unused_ir = ^IR[26:0];

  // IR is expected to present the fetched instruction from T2 until T0.
  control_decode u_decode (
    .opcode      (IR[31:27]),
    .instr_class (w_class)
  );

  always_comb begin
    w_next = S_T0;
    case (r_state)
      S_RESET:  w_next = S_T0;
      S_HALT:   w_next = S_HALT;
      S_T0:     w_next = Stop ? S_HALT : S_T1;
      S_T1:     w_next = S_T2;
      S_T2: begin
        case (w_class)
          CLS_ALU:                 w_next = S_ALU_T3;
          CLS_UNARY:               w_next = S_UN_T3;
          CLS_MULDIV:              w_next = S_MD_T3;
          CLS_IMM:                 w_next = S_IMM_T3;
          CLS_LD, CLS_LDI, CLS_ST: w_next = S_MEM_T3;
          CLS_BR:                  w_next = S_BR_T3;
          CLS_JR:                  w_next = S_JR_T3;
          CLS_JAL:                 w_next = S_JAL_T3;
          CLS_IN:                  w_next = S_IN_T3;
          CLS_OUT:                 w_next = S_OUT_T3;
          CLS_MFHI:                w_next = S_MFHI_T3;
          CLS_MFLO:                w_next = S_MFLO_T3;
          CLS_HALT:                w_next = S_HALT;
          default:                 w_next = S_T0;
        endcase
      end
      S_ALU_T3: w_next = S_ALU_T4;
      S_ALU_T4: w_next = S_ALU_T5;
      S_UN_T3:  w_next = S_UN_T4;
      S_UN_T4:  w_next = S_UN_T5;
      S_MD_T3:  w_next = S_MD_T4;
      S_MD_T4:  w_next = S_MD_T5;
      S_MD_T5:  w_next = S_MD_T6;
      S_IMM_T3: w_next = S_IMM_T4;
      S_IMM_T4: w_next = S_IMM_T5;
      S_MEM_T3: w_next = S_MEM_T4;
      S_MEM_T4: begin
        if (w_class == CLS_LD)       w_next = S_LD_T5;
        else if (w_class == CLS_LDI) w_next = S_LDI_T5;
        else                         w_next = S_ST_T5;
      end
      S_LD_T5:  w_next = S_LD_T6;
      S_LD_T6:  w_next = S_LD_T7;
      S_ST_T5:  w_next = S_ST_T6;
      S_ST_T6:  w_next = S_ST_T7;
      S_BR_T3:  w_next = S_BR_T4;
      S_BR_T4:  w_next = S_BR_T5;
      S_BR_T5:  w_next = S_BR_T6;
      S_JAL_T3: w_next = S_JAL_T4;
      default:  w_next = S_T0;
    endcase
  end

  // Controls are computed for the state being entered so every output is a flop.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RESET;
      r_ctrl  <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next, IR[31:27]);
      r_run   <= (w_next != S_HALT) && (w_next != S_RESET);
    end
  end

  assign Run       = r_run;
  assign op        = r_ctrl.op;
  assign PCout     = r_ctrl.pc_out;
  assign Zhighout  = r_ctrl.zhigh_out;
  assign Zlowout   = r_ctrl.zlow_out;
  assign MDRout    = r_ctrl.mdr_out;
  assign HIout     = r_ctrl.hi_out;
  assign LOout     = r_ctrl.lo_out;
  assign InPortout = r_ctrl.inport_out;
  assign Cout      = r_ctrl.c_out;
  assign BAout     = r_ctrl.ba_out;
  assign Rout      = r_ctrl.r_out;
  // Branch target load is the one output that follows the live CON result.
  assign PCin      = r_ctrl.pc_in | ((r_state == S_BR_T6) & branchCompare);
  assign IRin      = r_ctrl.ir_in;
  assign MARin     = r_ctrl.mar_in;
  assign MDRin     = r_ctrl.mdr_in;
  assign Yin       = r_ctrl.y_in;
  assign ZHighin   = r_ctrl.zhigh_in;
  assign Zlowin    = r_ctrl.zlow_in;
  assign HIin      = r_ctrl.hi_in;
  assign LOin      = r_ctrl.lo_in;
  assign OutPortin = r_ctrl.outport_in;
  assign CONin     = r_ctrl.con_in;
  assign Rin       = r_ctrl.r_in;
  assign Gra       = r_ctrl.gra;
  assign Grb       = r_ctrl.grb;
  assign Grc       = r_ctrl.grc;
  assign IncPC     = r_ctrl.inc_pc;
  assign Read      = r_ctrl.read;
  assign Write     = r_ctrl.write;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed step-by-step checks of the control_unit output sequences.
// Revision : 1.0
// ============================================================================
module tb_control_unit;

  logic        Clock, clear, branchCompare, Stop;
  logic [31:0] IR;
  logic        Run;
  logic [4:0]  op;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic        PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin, HIin, LOin, OutPortin, CONin, Rin;
  logic        Gra, Grb, Grc, IncPC, Read, Write;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .branchCompare(branchCompare), .Stop(Stop),
    .Run(Run), .op(op),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .ZHighin(ZHighin),
    .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [33:0] obs;
  assign obs = {Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
                PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin, HIin, LOin, OutPortin, CONin, Rin,
                Gra, Grb, Grc, IncPC, Read, Write, op};

  localparam logic [33:0] M_WRITE  = 34'd1 << 5,  M_READ   = 34'd1 << 6,  M_INCPC  = 34'd1 << 7;
  localparam logic [33:0] M_GRC    = 34'd1 << 8,  M_GRB    = 34'd1 << 9,  M_GRA    = 34'd1 << 10;
  localparam logic [33:0] M_RIN    = 34'd1 << 11, M_CONIN  = 34'd1 << 12, M_OPIN   = 34'd1 << 13;
  localparam logic [33:0] M_LOIN   = 34'd1 << 14, M_HIIN   = 34'd1 << 15, M_ZLIN   = 34'd1 << 16;
  localparam logic [33:0] M_ZHIN   = 34'd1 << 17, M_YIN    = 34'd1 << 18, M_MDRIN  = 34'd1 << 19;
  localparam logic [33:0] M_MARIN  = 34'd1 << 20, M_IRIN   = 34'd1 << 21, M_PCIN   = 34'd1 << 22;
  localparam logic [33:0] M_ROUT   = 34'd1 << 23, M_BAOUT  = 34'd1 << 24, M_COUT   = 34'd1 << 25;
  localparam logic [33:0] M_INPOUT = 34'd1 << 26, M_LOOUT  = 34'd1 << 27, M_HIOUT  = 34'd1 << 28;
  localparam logic [33:0] M_MDROUT = 34'd1 << 29, M_ZLOUT  = 34'd1 << 30, M_ZHOUT  = 34'd1 << 31;
  localparam logic [33:0] M_PCOUT  = 34'd1 << 32, M_RUN    = 34'd1 << 33;

  localparam logic [33:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZHIN | M_ZLIN;
  localparam logic [33:0] F1 = M_RUN | M_ZLOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [33:0] F2 = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [33:0] OP_ADD = 34'h03;
  localparam logic [33:0] OP_MUL = 34'h10;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_asserted: got %h expected %h", obs, 34'h0);
    end
    tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL reset_release_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_add();
    logic [33:0] ev [7];
    ev = '{F0, F1, F2, M_RUN | M_GRB | M_ROUT | M_YIN,
           M_RUN | M_GRC | M_ROUT | M_ZHIN | M_ZLIN | OP_ADD,
           M_RUN | M_ZLOUT | M_GRA | M_RIN, F0};
    IR = {5'b00011, 27'h12345};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL add step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_br(input logic bc);
    logic [33:0] ev [8];
    ev = '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_CONIN, M_RUN | M_PCOUT | M_YIN,
           M_RUN | M_COUT | M_ZHIN | M_ZLIN | OP_ADD,
           M_RUN | M_ZLOUT | (bc ? M_PCIN : 34'h0), F0};
    IR = {5'b10011, 27'h0};
    branchCompare = bc;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL br(bc=%0b) step %0d: got %h expected %h", bc, i, obs, ev[i]);
      end
    end
    branchCompare = 1'b0;
  endtask

  task automatic test_jal();
    logic [33:0] ev [6];
    ev = '{F0, F1, F2, M_RUN | M_PCOUT | M_GRB | M_RIN, M_RUN | M_GRA | M_ROUT | M_PCIN, F0};
    IR = {5'b10101, 27'h0};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL jal step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_st();
    logic [33:0] ev [9];
    ev = '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YIN,
           M_RUN | M_COUT | M_ZHIN | M_ZLIN | OP_ADD, M_RUN | M_ZLOUT | M_MARIN,
           M_RUN | M_GRA | M_ROUT | M_MDRIN, M_RUN | M_WRITE, F0};
    IR = {5'b00010, 27'h0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL st step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [33:0] ev [8];
    ev = '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_YIN,
           M_RUN | M_GRB | M_ROUT | M_ZHIN | M_ZLIN | OP_MUL,
           M_RUN | M_ZLOUT | M_LOIN, M_RUN | M_ZHOUT | M_HIIN, F0};
    IR = {5'b10000, 27'h0};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL mul step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_short(input logic [4:0] opc, input logic [33:0] t3);
    logic [33:0] ev [5];
    ev = '{F0, F1, F2, t3, F0};
    IR = {opc, 27'h0};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL short op=%b step %0d: got %h expected %h", opc, i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_nop(input logic [4:0] opc);
    logic [33:0] ev [4];
    ev = '{F0, F1, F2, F0};
    IR = {opc, 27'h0};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL nop op=%b step %0d: got %h expected %h", opc, i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_ldi();
    logic [33:0] ev [7];
    ev = '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YIN,
           M_RUN | M_COUT | M_ZHIN | M_ZLIN | OP_ADD, M_RUN | M_ZLOUT | M_GRA | M_RIN, F0};
    IR = {5'b00001, 27'h0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL ldi step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_ld();
    logic [33:0] ev [6];
    ev = '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YIN,
           M_RUN | M_COUT | M_ZHIN | M_ZLIN | OP_ADD, M_RUN | M_ZLOUT | M_MARIN};
    IR = {5'b00000, 27'h0};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL ld step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (obs !== 34'h0) begin
      n_fail++;
      $display("FAIL ld_mid_reset: got %h expected %h", obs, 34'h0);
    end
    tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL ld_reset_release_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_halt();
    logic [33:0] ev [7];
    ev = '{F0, F1, F2, 34'h0, 34'h0, 34'h0, 34'h0};
    IR = {5'b11011, 27'h0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      if (i == 4) Stop = 1'b1;
      if (i == 5) Stop = 1'b0;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL halt step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
    clear = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL halt_clear_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_stop();
    logic [33:0] ev [4];
    ev = '{F0, 34'h0, 34'h0, 34'h0};
    IR = {5'b00011, 27'h0};
    Stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (i == 2) Stop = 1'b0;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL stop step %0d: got %h expected %h", i, obs, ev[i]);
      end
    end
    clear = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL stop_clear_t0: got %h expected %h", obs, F0);
    end
  endtask

  initial begin
    IR            = 32'h0;
    branchCompare = 1'b0;
    Stop          = 1'b0;
    clear         = 1'b1;
    test_reset();
    test_add();
    test_br(1'b1);
    test_br(1'b0);
    test_jal();
    test_st();
    test_mul();
    test_ldi();
    test_short(5'b10110, M_RUN | M_INPOUT | M_GRA | M_RIN);
    test_short(5'b11000, M_RUN | M_HIOUT | M_GRA | M_RIN);
    test_short(5'b10100, M_RUN | M_GRA | M_ROUT | M_PCIN);
    test_nop(5'b11010);
    test_nop(5'b11110);
    test_reset_mid_ld();
    test_halt();
    test_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
